instr_decode_pipe: RTL and testbench
====================================

Name: instr_decode_pipe

Overview:
Parametrised successor to the single-cycle decoder. It is a handshaked decode stage between fetch and execute, and decodes the full RV32I base opcode set. Immediates are sign-extended to XLEN, and register operands are read from the register file. A per-register scoreboard stalls on RAW/WAW hazards until the producing instruction writes back. Output is a single registered pipeline slot with valid/ready backpressure and a branch flush.

Parameters:
WD_INSTR, 32, instruction width; must be 32.
XLEN, 32, datapath width; 32 or 64; immediates sign-extended to this width.
N_REGS, 32, architectural registers; x0 hard-wired zero and never pending.
WD_ADDR, $clog2(N_REGS), derived localparam, register address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_valid  in  1  fetch presents instruction
o_ready  out  1  decode accepts; transfer when i_valid && o_ready
i_instr  in  WD_INSTR  instruction word
i_pc  in  XLEN  PC of i_instr
o_reg_rd_addr  out  2*WD_ADDR  [0]=rs1, [1]=rs2, combinational from i_instr
i_reg_rd_data  in  2*XLEN  same-cycle (combinational) regfile read data
i_wb_valid  in  1  writeback retiring a register write
i_wb_addr  in  WD_ADDR  writeback destination
i_flush  in  1  kill output slot (branch mispredict)
o_valid  out  1  output slot holds decoded instruction
i_ready  in  1  execute accepts; transfer when o_valid && i_ready
o_op  out  operation_t  decoded operation (arriskv_pkg enum)
o_imm  out  XLEN  sign-extended immediate
o_rdest  out  WD_ADDR  destination (0 if none)
o_arg1, o_arg2  out  XLEN  rs1/rs2 values (0 if unused)
o_pc  out  XLEN  PC of decoded instruction
o_jump  out  1  JAL/JALR/branch
o_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset: o_valid=0, scoreboard all clear. o_op=NOP; o_imm, o_rdest, o_arg1, o_arg2, o_pc, o_jump, o_illegal all 0. Reset mid-stall drops the held instruction.
- Latency: 1 cycle from accept to o_valid. Back-to-back throughput 1/cycle when i_ready=1 and no hazards.
- slot_free = !o_valid || i_ready.
- hazard = (rs1 used && pend[rs1]) || (rs2 used && pend[rs2]) || (rd written && pend[rd]).
- o_ready = slot_free && !hazard && !i_flush. o_ready may depend on i_instr; fetch must hold i_instr stable while i_valid=1.
- Accept: register decoded fields; o_valid=1; set pend[rd] if rd!=0 and the op writes rd.
- Slot occupied, i_ready=0: hold all outputs stable.
- Slot drained, no accept: o_valid=0 next cycle.
- i_wb_valid: clear pend[i_wb_addr] next cycle. Same-cycle set and clear of the same register: set wins. i_wb_addr=0 is ignored.
- i_flush: o_valid=0 next cycle, no accept that cycle. If the slot holds a valid instruction not transferring this cycle, clear its pend[rd]. Flush has priority over i_ready.
- Opcodes: LOAD, STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH.
  - FENCE and SYSTEM: o_op=NOP, o_illegal=0.
  - Any other opcode, or undefined funct3/funct7: o_op=NOP, o_illegal=1, rd not marked pending.
- Shifts: SRLI when instr[30]=0, SRAI when instr[30]=1. R-type funct3 110/111 decode to OR/AND.
- Immediates (bit-exact RISC-V I/S/B/U/J formats):
  - I/S/B/J sign-extended from instr[31].
  - U = {instr[31:12], 12'b0}, sign-extended to XLEN.
  - R-type o_imm=0.
- o_arg1 = i_reg_rd_data[0] when rs1 used, else 0. Same rule for o_arg2 with rs2. Register x0 always reads 0.

Optional Feature:
WB_BYPASS_EN:
- Defined: a hazard whose only cause is register i_wb_addr (with i_wb_valid=1) in the current cycle is not a hazard. The instruction is accepted that cycle, and o_arg1/o_arg2 take bypass data from i_wb_data.
- Adds port i_wb_data  in  XLEN.
- Undefined: no i_wb_data port; the instruction issues the cycle after pend clears (one extra stall cycle).

Test Plan:
- ADDI x1,x0,5 (0x00500093), i_ready=1 -> next cycle o_valid=1, o_op=ADDI, o_imm=5, o_rdest=1, pend[1]=1.
- Then ADD x2,x1,x1 (0x00108133) -> o_ready=0 until i_wb_valid with i_wb_addr=1. Without WB_BYPASS_EN, accepted the cycle after writeback; with it, the same cycle, o_arg1=o_arg2=i_wb_data.
- ADDI x3,x0,-1 (0xFFF00193), XLEN=64 -> o_imm=0xFFFF_FFFF_FFFF_FFFF.
- Slot valid, i_ready=0 for 3 cycles -> outputs stable, o_ready=0. i_ready=1 with new instruction pending -> accepted the same cycle, o_valid stays 1.
- Slot holds LW x5 (rd=5), i_flush=1 -> o_valid=0 next cycle, pend[5]=0.
- Opcode 0x0000007F -> o_illegal=1, o_op=NOP, no pending bit set. BEQ (0x00000063) -> o_jump=1, o_rdest=0.

Source files
------------

// File: rtl/instr_decode_pipe.sv
// RV32I decode stage with a per-register pending scoreboard and one registered output slot.
// Define WB_BYPASS_EN to issue on the writeback cycle, taking operands from i_wb_data.
package arriskv_pkg;
  typedef enum logic [5:0] {
    NOP, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } operation_t;
endpackage

module instr_decode_pipe
  import arriskv_pkg::*;
#(
  parameter int WD_INSTR = 32,
  parameter int XLEN     = 32,
  parameter int N_REGS   = 32,
  localparam int WD_ADDR = $clog2(N_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WD_INSTR-1:0]  i_instr,
  input  logic [XLEN-1:0]      i_pc,
  output logic [2*WD_ADDR-1:0] o_reg_rd_addr,
  input  logic [2*XLEN-1:0]    i_reg_rd_data,
  input  logic                 i_wb_valid,
  input  logic [WD_ADDR-1:0]   i_wb_addr,
`ifdef WB_BYPASS_EN
  input  logic [XLEN-1:0]      i_wb_data,
`endif
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output operation_t           o_op,
  output logic [XLEN-1:0]      o_imm,
  output logic [WD_ADDR-1:0]   o_rdest,
  output logic [XLEN-1:0]      o_arg1,
  output logic [XLEN-1:0]      o_arg2,
  output logic [XLEN-1:0]      o_pc,
  output logic                 o_jump,
  output logic                 o_illegal
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [WD_ADDR-1:0] rs1, rs2, rd;
  logic signed [11:0] raw_i, raw_s;
  logic signed [12:0] raw_b;
  logic signed [20:0] raw_j;
  logic signed [31:0] raw_u;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd  = WD_ADDR'(i_instr[11:7]);
  assign rs1 = WD_ADDR'(i_instr[19:15]);
  assign rs2 = WD_ADDR'(i_instr[24:20]);
  assign o_reg_rd_addr = {rs2, rs1};

  // Signed intermediates so the size casts below sign-extend to XLEN.
  assign raw_i = i_instr[31:20];
  assign raw_s = {i_instr[31:25], i_instr[11:7]};
  assign raw_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign raw_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign raw_u = {i_instr[31:12], 12'b0};
  assign imm_i = XLEN'(raw_i);
  assign imm_s = XLEN'(raw_s);
  assign imm_b = XLEN'(raw_b);
  assign imm_j = XLEN'(raw_j);
  assign imm_u = XLEN'(raw_u);

  operation_t dec_op;
  logic [XLEN-1:0] dec_imm;
  logic use_rs1, use_rs2, wr_rd, dec_jump, dec_ill;

  always_comb begin
    dec_op = NOP; dec_imm = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    wr_rd = 1'b0; dec_jump = 1'b0; dec_ill = 1'b0;
    case (opcode)
      7'b0110111: begin dec_op = LUI;   dec_imm = imm_u; wr_rd = 1'b1; end
      7'b0010111: begin dec_op = AUIPC; dec_imm = imm_u; wr_rd = 1'b1; end
      7'b1101111: begin dec_op = JAL;   dec_imm = imm_j; wr_rd = 1'b1; dec_jump = 1'b1; end
      7'b1100111: begin
        dec_op = JALR; dec_imm = imm_i; use_rs1 = 1'b1; wr_rd = 1'b1; dec_jump = 1'b1;
        dec_ill = (funct3 != 3'b000);
      end
      7'b1100011: begin
        dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_jump = 1'b1;
        case (funct3)
          3'b000: dec_op = BEQ;
          3'b001: dec_op = BNE;
          3'b100: dec_op = BLT;
          3'b101: dec_op = BGE;
          3'b110: dec_op = BLTU;
          3'b111: dec_op = BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i; use_rs1 = 1'b1; wr_rd = 1'b1;
        case (funct3)
          3'b000: dec_op = LB;
          3'b001: dec_op = LH;
          3'b010: dec_op = LW;
          3'b100: dec_op = LBU;
          3'b101: dec_op = LHU;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (funct3)
          3'b000: dec_op = SB;
          3'b001: dec_op = SH;
          3'b010: dec_op = SW;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_imm = imm_i; use_rs1 = 1'b1; wr_rd = 1'b1;
        case (funct3)
          3'b000: dec_op = ADDI;
          3'b010: dec_op = SLTI;
          3'b011: dec_op = SLTIU;
          3'b100: dec_op = XORI;
          3'b110: dec_op = ORI;
          3'b111: dec_op = ANDI;
          3'b001: if (funct7 == 7'b0) dec_op = SLLI; else dec_ill = 1'b1;
          default: begin
            if ({funct7[6], funct7[4:0]} == 6'b0) dec_op = funct7[5] ? SRAI : SRLI;
            else dec_ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: dec_op = ADD;
            3'b001: dec_op = SLL;
            3'b010: dec_op = SLT;
            3'b011: dec_op = SLTU;
            3'b100: dec_op = XOR;
            3'b101: dec_op = SRL;
            3'b110: dec_op = OR;
            default: dec_op = AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_op = SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec_op = SRA;
        else dec_ill = 1'b1;
      end
      7'b0001111, 7'b1110011: dec_op = NOP;
      default: dec_ill = 1'b1;
    endcase
    // Illegal words carry no operands or destination, so they never stall or mark pending.
    if (dec_ill) begin
      dec_op = NOP; dec_imm = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      wr_rd = 1'b0; dec_jump = 1'b0;
    end
  end

  logic [N_REGS-1:0] pend, pend_eff, pend_next;
  logic [XLEN-1:0] src1, src2;
  logic hazard, accept;

  always_comb begin
    pend_eff = pend;
    src1 = i_reg_rd_data[XLEN-1:0];
    src2 = i_reg_rd_data[2*XLEN-1:XLEN];
`ifdef WB_BYPASS_EN
    if (i_wb_valid) begin
      pend_eff[i_wb_addr] = 1'b0;
      if (i_wb_addr == rs1) src1 = i_wb_data;
      if (i_wb_addr == rs2) src2 = i_wb_data;
    end
`endif
  end

  assign hazard = (use_rs1 && pend_eff[rs1]) || (use_rs2 && pend_eff[rs2]) ||
                  (wr_rd && pend_eff[rd]);
  assign o_ready = (!o_valid || i_ready) && !hazard && !i_flush;
  assign accept  = i_valid && o_ready;

  always_comb begin
    pend_next = pend;
    if (i_wb_valid) pend_next[i_wb_addr] = 1'b0;
    if (i_flush && o_valid && !i_ready) pend_next[o_rdest] = 1'b0;
    if (accept && wr_rd) pend_next[rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0; o_valid <= 1'b0; o_op <= NOP; o_imm <= '0; o_rdest <= '0;
      o_arg1 <= '0; o_arg2 <= '0; o_pc <= '0; o_jump <= 1'b0; o_illegal <= 1'b0;
    end else begin
      pend <= pend_next;
      if (i_flush) o_valid <= 1'b0;
      else if (accept) begin
        o_valid   <= 1'b1;
        o_op      <= dec_op;
        o_imm     <= dec_imm;
        o_rdest   <= wr_rd ? rd : '0;
        o_arg1    <= (use_rs1 && rs1 != '0) ? src1 : '0;
        o_arg2    <= (use_rs2 && rs2 != '0) ? src2 : '0;
        o_pc      <= i_pc;
        o_jump    <= dec_jump;
        o_illegal <= dec_ill;
      end else if (i_ready) o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed bench for instr_decode_pipe (XLEN=64): expected slot contents queued at accept,
// checked while the slot is held and popped when it transfers or is flushed.
module tb_instr_decode_pipe;
  import arriskv_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_valid, o_ready, i_wb_valid, i_flush, o_valid, i_ready, o_jump, o_illegal;
  logic [31:0] i_instr;
  logic [XLEN-1:0] i_pc, o_imm, o_arg1, o_arg2, o_pc;
  logic [9:0] o_reg_rd_addr;
  logic [2*XLEN-1:0] i_reg_rd_data;
  logic [4:0] i_wb_addr, o_rdest;
  operation_t o_op;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] i_wb_data;
`endif

  instr_decode_pipe #(.WD_INSTR(32), .XLEN(XLEN), .N_REGS(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_pc(i_pc), .o_reg_rd_addr(o_reg_rd_addr), .i_reg_rd_data(i_reg_rd_data),
    .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr),
`ifdef WB_BYPASS_EN
    .i_wb_data(i_wb_data),
`endif
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op), .o_imm(o_imm),
    .o_rdest(o_rdest), .o_arg1(o_arg1), .o_arg2(o_arg2), .o_pc(o_pc), .o_jump(o_jump),
    .o_illegal(o_illegal)
  );

  // Register file: xN reads 0x100+N (x0 included, so the decoder must zero it).
  always_comb i_reg_rd_data = {64'h100 + 64'(o_reg_rd_addr[9:5]), 64'h100 + 64'(o_reg_rd_addr[4:0])};

  typedef struct {
    operation_t op; logic [63:0] imm; logic [4:0] rd; logic [63:0] a1, a2, pc;
    logic jump, ill, strict;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int total = 0, bad = 0;
  int exp_ready = -1;
  bit exp_valid = 1'b0;

  function automatic exp_t mk(operation_t op, logic [63:0] imm, logic [4:0] rd,
                              logic [63:0] a1, logic [63:0] a2, logic [63:0] pc,
                              logic jump, logic ill, logic strict);
    exp_t e;
    e.op = op; e.imm = imm; e.rd = rd; e.a1 = a1; e.a2 = a2; e.pc = pc;
    e.jump = jump; e.ill = ill; e.strict = strict;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_out(input exp_t e);
    chk("o_op", 64'(o_op), 64'(e.op));
    chk("o_rdest", 64'(o_rdest), 64'(e.rd));
    chk("o_pc", o_pc, e.pc);
    chk("o_jump", 64'(o_jump), 64'(e.jump));
    chk("o_illegal", 64'(o_illegal), 64'(e.ill));
    if (e.strict) begin
      chk("o_imm", o_imm, e.imm);
      chk("o_arg1", o_arg1, e.a1);
      chk("o_arg2", o_arg2, e.a2);
    end
  endtask

  // One cycle: sample on the falling edge, update the model, return 1ns after the next rise.
  task automatic tick();
    bit acc;
    @(negedge clk);
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
    end else begin
      chk("o_valid", 64'(o_valid), 64'(exp_valid));
      if (exp_ready >= 0) chk("o_ready", 64'(o_ready), 64'(exp_ready));
      if (exp_valid) begin
        if (q.size() == 0) chk("queue_underflow", 64'(1), 64'(0));
        else begin
          cmp_out(q[0]);
          if (i_ready || i_flush) void'(q.pop_front());
        end
      end
      acc = i_valid && (exp_ready == 1);
      exp_valid = acc || (exp_valid && !i_ready && !i_flush);
      if (acc) q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
    i_valid = 1'b1; i_instr = ins; i_pc = pc; cur_exp = e;
  endtask

  logic [63:0] a_add;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_wb_valid = 1'b0; i_wb_addr = '0;
    i_flush = 1'b0; i_ready = 1'b1;
`ifdef WB_BYPASS_EN
    i_wb_data = 64'hABCD;
    a_add = 64'hABCD;
`else
    a_add = 64'h101;
`endif
    tick(); tick();
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_op", 64'(o_op), 64'(NOP));
    chk("rst_imm", o_imm, 64'(0));
    chk("rst_rdest", 64'(o_rdest), 64'(0));
    chk("rst_args", o_arg1 | o_arg2 | o_pc, 64'(0));
    chk("rst_flags", 64'({o_jump, o_illegal}), 64'(0));
    rst = 1'b0;

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1
    present(32'h00500093, 64'h100, mk(ADDI, 64'd5, 5'd1, 64'h0, 64'h0, 64'h100, 1'b0, 1'b0, 1'b1));
    #1 chk("rd_addr", 64'(o_reg_rd_addr), 64'({5'd5, 5'd0}));
    exp_ready = 1; tick();
    present(32'h00108133, 64'h104, mk(ADD, 64'd0, 5'd2, a_add, a_add, 64'h104, 1'b0, 1'b0, 1'b1));
    exp_ready = 0; tick(); tick(); tick();
    i_wb_valid = 1'b1; i_wb_addr = 5'd1;
`ifdef WB_BYPASS_EN
    exp_ready = 1; tick(); i_wb_valid = 1'b0;
`else
    exp_ready = 0; tick(); i_wb_valid = 1'b0;
    exp_ready = 1; tick();
`endif

    // ADDI x3,x0,-1 while x2 retires
    present(32'hFFF00193, 64'h108, mk(ADDI, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'h0, 64'h0, 64'h108, 1'b0, 1'b0, 1'b1));
    i_wb_valid = 1'b1; i_wb_addr = 5'd2;
    exp_ready = 1; tick(); i_wb_valid = 1'b0;

    // Backpressure: slot held three cycles, then drains and accepts in the same cycle
    i_ready = 1'b0;
    present(32'h00700213, 64'h10C, mk(ADDI, 64'd7, 5'd4, 64'h0, 64'h0, 64'h10C, 1'b0, 1'b0, 1'b1));
    exp_ready = 0; tick(); tick(); tick();
    i_ready = 1'b1; exp_ready = 1; tick();

    // LW x5,0(x6), held then flushed; pend[5] must be released
    present(32'h00032283, 64'h110, mk(LW, 64'd0, 5'd5, 64'h106, 64'h0, 64'h110, 1'b0, 1'b0, 1'b1));
    exp_ready = 1; tick();
    i_valid = 1'b0; i_ready = 1'b0; exp_ready = -1; tick();
    i_flush = 1'b1; exp_ready = 0; tick();
    i_flush = 1'b0; i_ready = 1'b1;
    present(32'h00100293, 64'h114, mk(ADDI, 64'd1, 5'd5, 64'h0, 64'h0, 64'h114, 1'b0, 1'b0, 1'b1));
    exp_ready = 1; tick();

    // Illegal opcode, illegal funct7 (MUL x7), then x7 must be free
    present(32'h0000007F, 64'h118, mk(NOP, 64'd0, 5'd0, 64'h0, 64'h0, 64'h118, 1'b0, 1'b1, 1'b0));
    tick();
    present(32'h021083B3, 64'h11C, mk(NOP, 64'd0, 5'd0, 64'h0, 64'h0, 64'h11C, 1'b0, 1'b1, 1'b0));
    tick();
    present(32'h00200393, 64'h120, mk(ADDI, 64'd2, 5'd7, 64'h0, 64'h0, 64'h120, 1'b0, 1'b0, 1'b1));
    tick();

    // Branches, LUI, store, fence, JAL, SRAI
    present(32'h00000063, 64'h124, mk(BEQ, 64'd0, 5'd0, 64'h0, 64'h0, 64'h124, 1'b1, 1'b0, 1'b1));
    tick();
    present(32'hFE209EE3, 64'h128, mk(BNE, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 64'h101, 64'h102, 64'h128, 1'b1, 1'b0, 1'b1));
    tick();
    present(32'h80000437, 64'h12C, mk(LUI, 64'hFFFF_FFFF_8000_0000, 5'd8, 64'h0, 64'h0, 64'h12C, 1'b0, 1'b0, 1'b1));
    tick();
    present(32'hFE112C23, 64'h130, mk(SW, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 64'h102, 64'h101, 64'h130, 1'b0, 1'b0, 1'b1));
    tick();
    present(32'h0000000F, 64'h134, mk(NOP, 64'd0, 5'd0, 64'h0, 64'h0, 64'h134, 1'b0, 1'b0, 1'b1));
    tick();
    present(32'h001000EF, 64'h138, mk(JAL, 64'h800, 5'd1, 64'h0, 64'h0, 64'h138, 1'b1, 1'b0, 1'b1));
    tick();
    present(32'h40335493, 64'h13C, mk(SRAI, 64'h403, 5'd9, 64'h106, 64'h0, 64'h13C, 1'b0, 1'b0, 1'b1));
    tick();

    // WAW on x1 (pending from JAL)
    present(32'h00100093, 64'h140, mk(ADDI, 64'd1, 5'd1, 64'h0, 64'h0, 64'h140, 1'b0, 1'b0, 1'b1));
    exp_ready = 0; tick(); tick();
    i_wb_valid = 1'b1; i_wb_addr = 5'd1;
`ifdef WB_BYPASS_EN
    exp_ready = 1; tick(); i_wb_valid = 1'b0;
`else
    exp_ready = 0; tick(); i_wb_valid = 1'b0;
    exp_ready = 1; tick();
`endif

    // ADD x10,x1,x0 stalls on x1; reset clears the scoreboard
    present(32'h00008533, 64'h144, mk(ADD, 64'd0, 5'd10, 64'h101, 64'h0, 64'h144, 1'b0, 1'b0, 1'b1));
    exp_ready = 0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; exp_ready = 1; tick();

    i_valid = 1'b0; exp_ready = -1; tick(); tick();
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
